// File: rtl/hex_display_scanner.sv
// -----------------------------------------------------------------------------
// hex_display_scanner
//   Time-multiplexed scan controller for a common-anode multi-digit 7-segment
//   display. A packed hex value is accepted over a valid/ready port into a
//   pending buffer and is copied into the displayed (shadow) buffer only at
//   the end of a full frame, so a frame never mixes old and new digits.
//
// Parameters
//   DIGITS        number of digits scanned; digit 0 = nibble [3:0], rightmost
//   DWELL_CYCLES  clk cycles each digit is driven (>= 1)
//   BLANK_CYCLES  clk cycles with all digits off between digits (0 = none)
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous reset, active-low
//   load_data   packed hex value to display (4*DIGITS bits)
//   load_dp     decimal-point request per digit, 1 = lit
//   load_valid  load request
//   load_ready  1 = pending buffer empty, load accepted this cycle
//   seg_out     segments {g,f,e,d,c,b,a}, active-low
//   dp_out      decimal point, active-low
//   digit_en    anode enables, active-low, at most one low at a time
//   frame_done  one-cycle pulse at the end of each full scan frame
//
// Build option
//   LEADING_ZERO_BLANK_EN : when defined, digits above the most significant
//   nonzero nibble are blanked (digit 0 is always shown).
// -----------------------------------------------------------------------------
module hex_display_scanner #(
   parameter int DIGITS       = 4,
   parameter int DWELL_CYCLES = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   load_data,
   input  logic [DIGITS-1:0]     load_dp,
   input  logic                  load_valid,
   output logic                  load_ready,
   output logic [6:0]            seg_out,
   output logic                  dp_out,
   output logic [DIGITS-1:0]     digit_en,
   output logic                  frame_done
);

   localparam int CNT_MAX    = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
   localparam int IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int DWELL_LAST = DWELL_CYCLES - 1;
   localparam int BLANK_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;

   typedef enum logic [0:0] {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [4*DIGITS-1:0]   shadow_q, shadow_d;
   logic [DIGITS-1:0]     shadow_dp_q, shadow_dp_d;
   logic [4*DIGITS-1:0]   pend_q, pend_d;
   logic [DIGITS-1:0]     pend_dp_q, pend_dp_d;
   logic                  pending_q, pending_d;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic [DIGITS-1:0]     digit_en_q, digit_en_d;
   logic                  frame_done_q, frame_done_d;
   logic                  enter_drive;
   logic                  enter_blank;

   // Hex digit to active-low {g,f,e,d,c,b,a}
   function automatic logic [6:0] font(input logic [3:0] n);
      case (n)
         4'h0:    font = 7'h40;
         4'h1:    font = 7'h79;
         4'h2:    font = 7'h24;
         4'h3:    font = 7'h30;
         4'h4:    font = 7'h19;
         4'h5:    font = 7'h12;
         4'h6:    font = 7'h02;
         4'h7:    font = 7'h78;
         4'h8:    font = 7'h00;
         4'h9:    font = 7'h18;
         4'hA:    font = 7'h08;
         4'hB:    font = 7'h03;
         4'hC:    font = 7'h27;
         4'hD:    font = 7'h21;
         4'hE:    font = 7'h06;
         default: font = 7'h0E;
      endcase
   endfunction

`ifdef LEADING_ZERO_BLANK_EN
   // Index of the most significant nonzero nibble; 0 when the value is zero
   function automatic int top_nonzero(input logic [4*DIGITS-1:0] v);
      top_nonzero = 0;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] != 4'h0) top_nonzero = i;
      end
   endfunction
`endif

   assign load_ready = ~pending_q;
   assign seg_out    = seg_q;
   assign dp_out     = dp_q;
   assign digit_en   = digit_en_q;
   assign frame_done = frame_done_q;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      shadow_d     = shadow_q;
      shadow_dp_d  = shadow_dp_q;
      pend_d       = pend_q;
      pend_dp_d    = pend_dp_q;
      pending_d    = pending_q;
      seg_d        = seg_q;
      dp_d         = dp_q;
      digit_en_d   = digit_en_q;
      frame_done_d = 1'b0;
      enter_drive  = 1'b0;
      enter_blank  = 1'b0;

      if (load_valid && !pending_q) begin
         pend_d    = load_data;
         pend_dp_d = load_dp;
         pending_d = 1'b1;
      end

      case (state_q)
         ST_BLANK: begin
            // Reset parks in BLANK even when no blanking is configured; leave after one cycle then
            if (BLANK_CYCLES == 0 || cnt_q == CNT_W'(BLANK_LAST)) begin
               state_d     = ST_DRIVE;
               cnt_d       = '0;
               enter_drive = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            if (cnt_q == CNT_W'(DWELL_LAST)) begin
               cnt_d = '0;
               if (idx_q == IDX_W'(DIGITS - 1)) begin
                  idx_d        = '0;
                  frame_done_d = 1'b1;
                  // Commit only at frame end so a frame never shows two values
                  if (pending_q) begin
                     shadow_d    = pend_q;
                     shadow_dp_d = pend_dp_q;
                     pending_d   = 1'b0;
                  end
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
               if (BLANK_CYCLES == 0) begin
                  state_d     = ST_DRIVE;
                  enter_drive = 1'b1;
               end else begin
                  state_d     = ST_BLANK;
                  enter_blank = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      endcase

      // Outputs follow the next state/digit on the same edge, using the
      // post-commit shadow so a fresh value appears first on digit 0
      if (enter_drive) begin
         digit_en_d = ~(DIGITS'(1) << idx_d);
         seg_d      = font(shadow_d[4*int'(idx_d) +: 4]);
         dp_d       = ~shadow_dp_d[idx_d];
`ifdef LEADING_ZERO_BLANK_EN
         if (int'(idx_d) > top_nonzero(shadow_d)) seg_d = 7'h7F;
`endif
      end else if (enter_blank) begin
         digit_en_d = '1;
         seg_d      = 7'h7F;
         dp_d       = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_BLANK;
         cnt_q        <= '0;
         idx_q        <= '0;
         shadow_q     <= '0;
         shadow_dp_q  <= '0;
         pend_q       <= '0;
         pend_dp_q    <= '0;
         pending_q    <= 1'b0;
         seg_q        <= 7'h7F;
         dp_q         <= 1'b1;
         digit_en_q   <= '1;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shadow_q     <= shadow_d;
         shadow_dp_q  <= shadow_dp_d;
         pend_q       <= pend_d;
         pend_dp_q    <= pend_dp_d;
         pending_q    <= pending_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         digit_en_q   <= digit_en_d;
         frame_done_q <= frame_done_d;
      end
   end

endmodule

// File: tb/tb_hex_display_scanner.sv
// -----------------------------------------------------------------------------
// tb_hex_display_scanner
//   Directed bench for hex_display_scanner with DIGITS=4, DWELL_CYCLES=4,
//   BLANK_CYCLES=2 (frame = 24 cycles). Inputs change and outputs are sampled
//   on the falling clock edge. Positions inside a frame are counted in rising
//   edges from the sample where frame_done is seen high: digit d is driven at
//   edge 2 + 6*d.
// -----------------------------------------------------------------------------
module tb_hex_display_scanner;

   localparam int DIGITS = 4;
`ifdef LEADING_ZERO_BLANK_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic [4*DIGITS-1:0] load_data = '0;
   logic [DIGITS-1:0]   load_dp = '0;
   logic                load_valid = 1'b0;
   logic                load_ready;
   logic [6:0]          seg_out;
   logic                dp_out;
   logic [DIGITS-1:0]   digit_en;
   logic                frame_done;

   int n_cmp = 0;
   int n_bad = 0;

   hex_display_scanner #(
      .DIGITS       (DIGITS),
      .DWELL_CYCLES (4),
      .BLANK_CYCLES (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .load_data  (load_data),
      .load_dp    (load_dp),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .seg_out    (seg_out),
      .dp_out     (dp_out),
      .digit_en   (digit_en),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   // Number of rising edges until frame_done is seen, bounded
   task automatic wait_fd(output int n);
      n = 0;
      while (frame_done !== 1'b1 && n < 60) begin
         step(1);
         n++;
      end
      if (frame_done !== 1'b1) check_val("fd_timeout", 32'(frame_done), 32'h1);
   endtask

   task automatic check_digit(input string tag, input int d, input logic [6:0] seg, input logic dp);
      logic [DIGITS-1:0] en;
      en = ~(DIGITS'(1) << d);
      check_val({tag, "_en"}, 32'(digit_en), 32'(en));
      check_val({tag, "_seg"}, 32'(seg_out), 32'(seg));
      check_val({tag, "_dp"}, 32'(dp_out), 32'(dp));
   endtask

   task automatic load(input logic [15:0] v, input logic [3:0] dp);
      load_data  = v;
      load_dp    = dp;
      load_valid = 1'b1;
      check_val("ld_ready_before", 32'(load_ready), 32'h1);
      step(1);
      load_valid = 1'b0;
      check_val("ld_ready_after", 32'(load_ready), 32'h0);
   endtask

   initial begin
      int n;

      // 1. reset values, first drive, frame period
      #23;
      check_val("rst_seg", 32'(seg_out), 32'h7F);
      check_val("rst_en", 32'(digit_en), 32'hF);
      check_val("rst_dp", 32'(dp_out), 32'h1);
      check_val("rst_ready", 32'(load_ready), 32'h1);
      check_val("rst_fd", 32'(frame_done), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      step(1);
      check_val("blank1_en", 32'(digit_en), 32'hF);
      step(1);
      check_digit("first_d0", 0, 7'h40, 1'b1);
      wait_fd(n);
      check_val("fd_first", 32'(n), 32'd22);
      step(1);
      check_val("fd_pulse", 32'(frame_done), 32'h0);
      wait_fd(n);
      check_val("fd_period", 32'(n + 1), 32'd24);

      // 2. load 1A3F, dp on digit 2; current frame keeps old value
      load(16'h1A3F, 4'b0100);
      step(1);
      check_digit("old_d0", 0, 7'h40, 1'b1);
      wait_fd(n);
      check_val("commit_ready", 32'(load_ready), 32'h1);
      step(2);  check_digit("v1_d0", 0, 7'h0E, 1'b1);
      step(6);  check_digit("v1_d1", 1, 7'h30, 1'b1);
      step(6);  check_digit("v1_d2", 2, 7'h08, 1'b0);
      step(6);  check_digit("v1_d3", 3, 7'h79, 1'b1);
      wait_fd(n);

      // 3/4. load mid-frame, then a held second request that must be ignored
      step(10);
      load_data  = 16'h2B4C;
      load_dp    = 4'b0001;
      load_valid = 1'b1;
      check_val("mid_ready", 32'(load_ready), 32'h1);
      step(1);
      load_data = 16'hFFFF;
      load_dp   = 4'b1111;
      check_val("busy_ready", 32'(load_ready), 32'h0);
      step(3);
      check_digit("notear_d2", 2, 7'h08, 1'b0);
      check_val("busy_ready2", 32'(load_ready), 32'h0);
      load_valid = 1'b0;
      step(6);  check_digit("notear_d3", 3, 7'h79, 1'b1);
      wait_fd(n);
      check_val("commit2_ready", 32'(load_ready), 32'h1);
      step(2);  check_digit("v2_d0", 0, 7'h27, 1'b0);
      step(6);  check_digit("v2_d1", 1, 7'h19, 1'b1);
      step(6);  check_digit("v2_d2", 2, 7'h03, 1'b1);
      step(6);  check_digit("v2_d3", 3, 7'h24, 1'b1);
      wait_fd(n);

      // 5. async reset during digit 2 drops pending load
      load(16'h5555, 4'b1111);
      step(13);
      check_digit("pre_rst_d2", 2, 7'h03, 1'b1);
      #2 rst = 1'b0;
      #1;
      check_val("arst_seg", 32'(seg_out), 32'h7F);
      check_val("arst_en", 32'(digit_en), 32'hF);
      check_val("arst_dp", 32'(dp_out), 32'h1);
      check_val("arst_ready", 32'(load_ready), 32'h1);
      @(negedge clk);
      rst = 1'b1;
      step(2);
      check_digit("post_rst_d0", 0, 7'h40, 1'b1);
      wait_fd(n);
      check_val("post_rst_fd", 32'(n), 32'd22);
      step(2);  check_digit("post_rst_d0b", 0, 7'h40, 1'b1);
      wait_fd(n);

      // 6. leading zeros: 0050 then 0000
      load(16'h0050, 4'b0000);
      wait_fd(n);
      step(2);  check_digit("lz_d0", 0, 7'h40, 1'b1);
      step(6);  check_digit("lz_d1", 1, 7'h12, 1'b1);
      step(6);  check_digit("lz_d2", 2, LZB ? 7'h7F : 7'h40, 1'b1);
      step(6);  check_digit("lz_d3", 3, LZB ? 7'h7F : 7'h40, 1'b1);
      wait_fd(n);
      load(16'h0000, 4'b0000);
      wait_fd(n);
      step(2);  check_digit("z_d0", 0, 7'h40, 1'b1);
      step(6);  check_digit("z_d1", 1, LZB ? 7'h7F : 7'h40, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
